// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage with a DEPTH-entry fetch buffer.
// Optional misaligned-redirect trap is enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0004
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction,
    output logic [31:0] IF_PC_Plus_4,
    output logic        if_valid,
    output logic        misalign_trap
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   tag_q [DEPTH];
    logic [31:0]   pc4_q [DEPTH];
    logic [31:0]   ins_q [DEPTH];
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] buf_rd;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic          issue;
    logic          resp;
    logic          keep;
    logic          consume;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] drop_nxt;
    logic [31:0]   target;
    logic          trap_nxt;

    // Credits: buffered entries plus in-flight requests never exceed DEPTH
    assign imem_req = (state == RUN) && !redirect &&
                      ((count + outstanding) < CW'(DEPTH));
    assign imem_addr = fetch_pc;

    assign issue   = imem_req && imem_gnt;
    assign resp    = imem_rvalid && (outstanding != '0);
    assign keep    = resp && (drop_cnt == '0) && !redirect;
    assign if_valid = (count != '0);
    assign consume = if_valid && !hold && !redirect;
    assign out_nxt = outstanding + CW'(issue) - CW'(resp);

    assign Instruction  = if_valid ? ins_q[buf_rd] : 32'h0;
    assign IF_PC_Plus_4 = if_valid ? pc4_q[buf_rd] : 32'h0;

`ifdef IF_MISALIGN_TRAP_EN
    assign trap_nxt = redirect && (redirect_pc[1:0] != 2'b00);
    assign target   = trap_nxt ? EXC_VECTOR : redirect_pc;
`else
    assign trap_nxt = 1'b0;
    assign target   = {redirect_pc[31:2], 2'b00};
`endif

    // A redirect while draining keeps the existing drop count
    always_comb begin
        drop_nxt = drop_cnt;
        if (redirect && (state != DRAIN))
            drop_nxt = out_nxt;
        else if (resp && (drop_cnt != '0))
            drop_nxt = drop_cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            fetch_pc      <= RESET_PC;
            tag_wr        <= '0;
            tag_rd        <= '0;
            buf_wr        <= '0;
            buf_rd        <= '0;
            count         <= '0;
            outstanding   <= '0;
            drop_cnt      <= '0;
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= trap_nxt;
            outstanding   <= out_nxt;
            drop_cnt      <= drop_nxt;
            unique case (state)
                BOOT:    state <= RUN;
                RUN:     if (redirect && (drop_nxt != '0)) state <= DRAIN;
                DRAIN:   if (drop_nxt == '0) state <= RUN;
                default: state <= BOOT;
            endcase
            if (redirect) begin
                fetch_pc <= target;
                tag_wr   <= '0;
                tag_rd   <= '0;
                buf_wr   <= '0;
                buf_rd   <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    tag_wr   <= tag_wr + PW'(1);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (keep)
                    tag_rd <= tag_rd + PW'(1);
                if (keep)
                    buf_wr <= buf_wr + PW'(1);
                if (consume)
                    buf_rd <= buf_rd + PW'(1);
                count <= count + CW'(keep) - CW'(consume);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            tag_q[tag_wr] <= fetch_pc;
        if (keep) begin
            pc4_q[buf_wr] <= tag_q[tag_rd] + 32'd4;
            ins_q[buf_wr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random stimulus against an in-order memory model
// and a PC-sequence scoreboard for the fetch stage.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        hold = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] Instruction;
    logic [31:0] IF_PC_Plus_4;
    logic        if_valid;
    logic        misalign_trap;

    if_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .hold(hold),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .Instruction(Instruction), .IF_PC_Plus_4(IF_PC_Plus_4),
        .if_valid(if_valid), .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          n_consumed = 0;
    logic [31:0] exp_iss = 32'h0;
    logic [31:0] exp_con = 32'h0;
    logic        trap_exp = 1'b0;
    logic        after_redirect = 1'b0;
    logic        held = 1'b0;
    logic        drain_exp = 1'b0;
    logic        first_run = 1'b0;

    task automatic step(input logic h, input logic r, input logic [31:0] rpc,
                        input logic g, input int lat);
        logic [31:0] tgt;
        logic        mis;
        logic        iss;
        logic        cons;
        @(negedge clk);
        hold        = h;
        redirect    = r;
        redirect_pc = rpc;
        imem_gnt    = g;
        imem_rvalid = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        imem_rdata  = imem_rvalid ? inst_of(mq_addr[0]) : 32'hDEAD_BEEF;
        #1;
        check("trap", misalign_trap, trap_exp);
        if (first_run) check("first_req", imem_req, 1);
        if (after_redirect) check("valid_after_redirect", if_valid, 0);
        if (held) check("hold_valid", if_valid, 1);
        if (drain_exp) check("drain_no_req", imem_req, 0);
        if (r) check("req_on_redirect", imem_req, 0);
        if (if_valid) begin
            check("pc_plus_4", IF_PC_Plus_4, exp_con + 32'd4);
            check("instr", Instruction, inst_of(exp_con));
        end else begin
            check("instr_zero", Instruction, 32'h0);
            check("pc4_zero", IF_PC_Plus_4, 32'h0);
        end
        if (imem_req) check("imem_addr", imem_addr, exp_iss);
        check("credit_bound", 32'(mq_addr.size() <= DEPTH), 1);

        iss  = imem_req && g;
        cons = if_valid && !h && !r;
        if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (iss) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + lat);
            exp_iss = exp_iss + 32'd4;
        end
        if (cons) begin
            exp_con = exp_con + 32'd4;
            n_consumed++;
        end
        trap_exp = 1'b0;
        if (r) begin
`ifdef IF_MISALIGN_TRAP_EN
            mis = (rpc[1:0] != 2'b00);
            tgt = mis ? 32'h8000_0004 : rpc;
`else
            mis = 1'b0;
            tgt = {rpc[31:2], 2'b00};
`endif
            exp_iss  = tgt;
            exp_con  = tgt;
            trap_exp = mis;
        end
        after_redirect = r;
        held      = if_valid && h && !r;
        drain_exp = r && (mq_addr.size() > 0);
        first_run = 1'b0;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        hold = 1'b0;
        redirect = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        repeat (n) begin
            @(negedge clk);
            #1;
            check("rst_req", imem_req, 0);
            check("rst_addr", imem_addr, 32'h0);
            check("rst_valid", if_valid, 0);
            check("rst_instr", Instruction, 32'h0);
            check("rst_pc4", IF_PC_Plus_4, 32'h0);
            check("rst_trap", misalign_trap, 0);
        end
        exp_iss = 32'h0;
        exp_con = 32'h0;
        trap_exp = 1'b0;
        after_redirect = 1'b0;
        held = 1'b0;
        drain_exp = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("boot_no_req", imem_req, 0);
        first_run = 1'b1;
    endtask

    task automatic rand_step();
        logic [31:0] rpc;
        int          sel;
        sel = $urandom_range(0, 9);
        rpc = $urandom;
        if (sel < 6) rpc[1:0] = 2'b00;
        else if (sel < 8) rpc = 32'hFFFF_FFF8 + 32'(4 * $urandom_range(0, 1));
        step(($urandom % 4) == 0, ($urandom % 20) == 0, rpc,
             ($urandom % 4) != 0, $urandom_range(1, 4));
    endtask

    initial begin
        do_reset(3);
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        check("hold_credits", imem_req, 0);
        check("hold_full", if_valid, 1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 3);
        step(1'b0, 1'b1, 32'h100, 1'b1, 3);
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 3);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        step(1'b0, 1'b1, 32'h102, 1'b1, 2);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 2);
        repeat (1500) rand_step();
        do_reset(2);
        repeat (400) rand_step();
        check("progress", 32'(n_consumed > 100), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
